// File: rtl/peripheral_keypad.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, key FIFO, bus registers.
// Optional macro KEYPAD_IRQ_EN adds a registered irq output and the CTRL[2] irq_en bit.
module peripheral_keypad #(
  parameter int unsigned SCAN_DIV   = 26000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  localparam logic [4:0] ADDR_STATUS = 5'h00;
  localparam logic [4:0] ADDR_DATA   = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [3:0] DEB_CNT     = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CAND,
    ST_PRESSED,
    ST_RELEASE_CAND
  } state_e;

  logic [3:0]       row_meta_q, row_sync_q;
  logic             ctrl_en_q, ctrl_en_d;
  logic             irq_en_c;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [1:0]       hits_q, hits_d, res_hits_c;
  logic [3:0]       code_q, code_d, res_code_c;
  logic [2:0]       row_hits_c;
  logic [1:0]       row_idx_c;
  logic             scan_run_c, scan_done_c;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_inc_c;
  logic [3:0]       cand_q, cand_d;
  logic             push_c;
  logic [3:0]       push_code_c;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      d_out_q, d_out_d;
  logic             rd_en_c, wr_ctrl_c, flush_c, pop_c, accept_c;
  logic             not_empty_c, full_c;

  // Bus decode and CTRL enable bit; flush is a write-1 pulse and never stored
  always_comb begin
    rd_en_c     = cs & rd;
    wr_ctrl_c   = cs & wr & (addr == ADDR_CTRL);
    flush_c     = wr_ctrl_c & d_in[1];
    ctrl_en_d   = wr_ctrl_c ? d_in[0] : ctrl_en_q;
    not_empty_c = (count_q != '0);
    full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    pop_c       = rd_en_c & (addr == ADDR_DATA) & not_empty_c;
  end

  // Column scan and per-scan accumulation of low rows
  always_comb begin
    div_d       = div_q;
    col_d       = col_q;
    hits_d      = hits_q;
    code_d      = code_q;
    res_hits_c  = hits_q;
    res_code_c  = code_q;
    scan_done_c = 1'b0;
    row_hits_c  = 3'd0;
    row_idx_c   = 2'd0;
    scan_run_c  = ctrl_en_q & ctrl_en_d;
    for (int i = 0; i < 4; i++) begin
      if (!row_sync_q[i]) row_hits_c = row_hits_c + 3'd1;
    end
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) row_idx_c = 2'(i);
    end
    if (!scan_run_c) begin
      div_d  = '0;
      col_d  = 2'd0;
      hits_d = 2'd0;
      code_d = 4'd0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      col_d = col_q + 2'd1;
      if (row_hits_c != 3'd0) begin
        if (hits_q == 2'd0 && row_hits_c == 3'd1) begin
          res_hits_c = 2'd1;
          res_code_c = {col_q, row_idx_c};
        end else begin
          res_hits_c = 2'd2;
        end
      end
      if (col_q == 2'd3) begin
        scan_done_c = 1'b1;
        hits_d      = 2'd0;
        code_d      = 4'd0;
      end else begin
        hits_d = res_hits_c;
        code_d = res_code_c;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    col_out_d = scan_run_c || (ctrl_en_d && !ctrl_en_q) ? ~(4'b0001 << col_d) : 4'hF;
  end

  // Debounce FSM; res_hits 0/1/2 = NONE/SINGLE/MULTI
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    push_c      = 1'b0;
    push_code_c = cand_q;
    cnt_inc_c   = cnt_q + 4'd1;
    if (!scan_run_c) begin
      state_d = ST_RELEASED;
      cnt_d   = 4'd0;
      cand_d  = 4'd0;
    end else if (scan_done_c) begin
      case (state_q)
        ST_RELEASED: begin
          if (res_hits_c == 2'd1) begin
            cand_d = res_code_c;
            if (DEB_CNT == 4'd1) begin
              push_c      = 1'b1;
              push_code_c = res_code_c;
              state_d     = ST_PRESSED;
              cnt_d       = 4'd0;
            end else begin
              state_d = ST_PRESS_CAND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_PRESS_CAND: begin
          if (res_hits_c == 2'd1 && res_code_c == cand_q) begin
            if (cnt_inc_c == DEB_CNT) begin
              push_c  = 1'b1;
              state_d = ST_PRESSED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            state_d = ST_RELEASED;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (res_hits_c == 2'd0) begin
            if (DEB_CNT == 4'd1) begin
              state_d = ST_RELEASED;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_RELEASE_CAND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_RELEASE_CAND: begin
          if (res_hits_c == 2'd0) begin
            if (cnt_inc_c == DEB_CNT) begin
              state_d = ST_RELEASED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Key FIFO: a pop frees the slot for a same-edge push; flush overrides everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    accept_c = push_c & (~full_c | pop_c);
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (accept_c) begin
        mem_d[wr_ptr_q] = push_code_c;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c && !accept_c) ovf_d = 1'b1;
      case ({accept_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Registered read data
  always_comb begin
    d_out_d = d_out_q;
    if (rd_en_c) begin
      case (addr)
        ADDR_STATUS: d_out_d = {24'd0, 4'(count_q), 1'b0, ovf_q, full_c, not_empty_c};
        ADDR_DATA:   d_out_d = not_empty_c ? {23'd0, 1'b1, 4'd0, mem_q[rd_ptr_q]} : 32'd0;
        ADDR_CTRL:   d_out_d = {29'd0, irq_en_c, 1'b0, ctrl_en_q};
        default:     d_out_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      ctrl_en_q  <= 1'b0;
      div_q      <= '0;
      col_q      <= 2'd0;
      col_out_q  <= 4'hF;
      hits_q     <= 2'd0;
      code_q     <= 4'd0;
      state_q    <= ST_RELEASED;
      cnt_q      <= 4'd0;
      cand_q     <= 4'd0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      d_out_q    <= 32'd0;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      ctrl_en_q  <= ctrl_en_d;
      div_q      <= div_d;
      col_q      <= col_d;
      col_out_q  <= col_out_d;
      hits_q     <= hits_d;
      code_q     <= code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      d_out_q    <= d_out_d;
    end
  end

`ifdef KEYPAD_IRQ_EN
  logic        irq_en_q, irq_en_d, irq_q, irq_d;
  logic [12:0] d_in_unused;

  always_comb begin
    irq_en_d = wr_ctrl_c ? d_in[2] : irq_en_q;
    irq_d    = irq_en_q & not_empty_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_c    = irq_en_q;
  assign irq         = irq_q;
  assign d_in_unused = d_in[15:3];
`else
  logic [13:0] d_in_unused;

  assign irq_en_c    = 1'b0;
  assign d_in_unused = d_in[15:2];
`endif

  assign d_out   = d_out_q;
  assign col_out = col_out_q;

endmodule

// File: tb/tb_peripheral_keypad.sv
// Scoreboard bench for peripheral_keypad: keypad matrix model, FIFO reference queue, bus tasks.
module tb_peripheral_keypad;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEBOUNCE   = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [4:0] A_STATUS = 5'h00;
  localparam logic [4:0] A_DATA   = 5'h04;
  localparam logic [4:0] A_CTRL   = 5'h08;

  logic        clk;
  logic        resetn;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_out;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_down;
  logic [3:0]  prev_col;
`ifdef KEYPAD_IRQ_EN
  logic        irq;
`endif

  int unsigned n_vec;
  int unsigned n_miscmp;
  logic [3:0]  exp_q[$];
  logic        m_ovf;

  peripheral_keypad #(
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .d_in   (d_in),
    .cs     (cs),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .d_out  (d_out),
    .row_in (row_in),
    .col_out(col_out)
`ifdef KEYPAD_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive switch matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (key_down[c*4+r] && col_out[c] == 1'b0) row_in[r] = 1'b0;
  end

  always @(posedge clk) prev_col <= col_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int unsigned n;
    n = exp_q.size();
    return {24'd0, 4'(n), 1'b0, m_ovf, (n == FIFO_DEPTH), (n != 0)};
  endfunction

  task automatic model_push(input logic [3:0] code);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(code);
    else m_ovf = 1'b1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'd0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    bus_read(A_STATUS, v);
    check(tag, v, exp_status());
  endtask

  task automatic check_data(input string tag);
    logic [31:0] v, e;
    bus_read(A_DATA, v);
    if (exp_q.size() != 0) e = {23'd0, 1'b1, 4'd0, exp_q.pop_front()};
    else e = 32'd0;
    check(tag, v, e);
  endtask

  // Returns at the negedge opening a new scan (column 0 just followed column 3)
  task automatic wait_scan_start();
    int t;
    t = 0;
    while (!(col_out == 4'b1110 && prev_col == 4'b0111) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("scan_sync", {24'd0, prev_col, col_out}, 32'h0000007e);
  endtask

  task automatic apply(input logic [15:0] k, input int n);
    wait_scan_start();
    key_down = k;
    repeat (n) begin
      @(negedge clk);
      wait_scan_start();
    end
  endtask

  task automatic press_release(input logic [3:0] code);
    logic [15:0] k;
    k = 16'd0;
    k[code] = 1'b1;
    apply(k, 2);
    model_push(code);
    apply(16'd0, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, e;
    logic [3:0]  codes4 [5];
    logic [3:0]  codes5 [4];
    int t;
    n_vec = 0; n_miscmp = 0;
    resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'd0; d_in = 16'd0;
    key_down = 16'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_d_out", d_out, 32'd0);
    check("rst_col_out", {28'd0, col_out}, 32'h0000000f);
    resetn = 1'b1;
    check_status("rst_status");

    // Single key col2/row1 held 5 scans then released 3 scans
    bus_write(A_CTRL, 16'h0001);
    apply(16'h0200, 5);
    model_push(4'd9);
    apply(16'd0, 3);
    check_status("single_status");
    check_data("single_data");
    check_status("single_status_after");

    // Bouncing key: one scan down, one scan up
    for (int i = 0; i < 4; i++) begin
      apply(16'h0020, 1);
      apply(16'd0, 1);
      check_status("bounce_status");
    end

    // Two keys together are ignored; the survivor is accepted
    apply(16'h8001, 4);
    check_status("multi_status");
    apply(16'h0001, 2);
    model_push(4'd0);
    apply(16'd0, 2);
    check_status("multi_single_status");
    check_data("multi_single_data");

    // Overflow: five keys into a four-deep FIFO
    codes4 = '{4'h3, 4'h6, 4'hC, 4'hF, 4'hA};
    foreach (codes4[i]) press_release(codes4[i]);
    check_status("ovf_status");
    for (int i = 0; i < 5; i++) check_data("ovf_data");
    check_status("ovf_drained_status");

    // Read coinciding with a push while full
    bus_write(A_CTRL, 16'h0003);
    model_clear();
    check_status("flush_status");
    codes5 = '{4'h1, 4'h2, 4'h4, 4'h8};
    foreach (codes5[i]) press_release(codes5[i]);
    check_status("full_status");
    apply(16'h4000, 1);
    t = 0;
    while (col_out != 4'b0111 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = A_DATA;
    @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0;
    e = {23'd0, 1'b1, 4'd0, exp_q.pop_front()};
    check("rd_push_data", v, e);
    model_push(4'hE);
    apply(16'd0, 2);
    check_status("rd_push_status");
    for (int i = 0; i < 4; i++) check_data("rd_push_order");
    press_release(4'h7);
    check_status("pre_flush_status");
    bus_write(A_CTRL, 16'h0003);
    model_clear();
    check_status("flush2_status");

    // Asynchronous reset in the middle of a dwell with a key held
    bus_read(A_CTRL, v);
    check("ctrl_readback", v, 32'h00000001);
    key_down = 16'h0020;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_col_out", {28'd0, col_out}, 32'h0000000f);
    check("arst_d_out", d_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    key_down = 16'd0;
    model_clear();
    check_status("arst_status");
    bus_read(A_CTRL, v);
    check("arst_ctrl", v, 32'd0);

`ifdef KEYPAD_IRQ_EN
    bus_write(A_CTRL, 16'h0005);
    press_release(4'h3);
    check("irq_set", {31'd0, irq}, 32'd1);
    check_data("irq_data");
    @(negedge clk);
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
